// File: rtl/mem_reg_bank_pkg.sv
// rtl/mem_reg_bank_pkg.sv - address map constants and decode helpers for mem_reg_bank
package mem_reg_bank_pkg;

    localparam int STAT_BASE = 0;
    localparam int CNT_BASE  = 8;
    localparam int CTRL_BASE = 16;

    localparam logic [15:0] DEFAULT_ID = 16'h0B16;

    // Each counter owns a low/high word pair starting at CNT_BASE.
    function automatic int cnt_lo_addr(input int idx);
        return CNT_BASE + 2 * idx;
    endfunction

    function automatic int cnt_hi_addr(input int idx);
        return CNT_BASE + 2 * idx + 1;
    endfunction

    // The ID word sits at the very top of the address space.
    function automatic int id_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/edge_event_counter.sv
// rtl/edge_event_counter.sv - status synchroniser, rising-edge detect, saturating counter with hi snapshot
//
// Ports:
//   clk, rst        bus clock, synchronous active-high reset
//   stat_in         asynchronous status level
//   clr             clear counter and snapshot (wins over a same-cycle event)
//   snap            latch the current counter high part into hi_snap
//   level           synchronised status level
//   cnt_lo          counter low word
//   hi_snap         counter high part as captured by the last snap
module edge_event_counter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stat_in,
    input  logic                      clr,
    input  logic                      snap,
    output logic                      level,
    output logic [DATA_W-1:0]         cnt_lo,
    output logic [CNT_W-DATA_W-1:0]   hi_snap
);

    logic             meta;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            hi_snap <= '0;
        end else begin
            meta    <= stat_in;
            level   <= meta;
            level_d <= level;
            if (clr)
                cnt <= '0;
            else if (level && !level_d && !(&cnt))
                cnt <= cnt + CNT_W'(1);
            // snapshot samples the pre-increment count so a low-word read
            // and its matching high-word read describe the same value
            if (clr)
                hi_snap <= '0;
            else if (snap)
                hi_snap <= cnt[CNT_W-1:DATA_W];
        end
    end

    assign cnt_lo = cnt[DATA_W-1:0];

endmodule

// File: rtl/mem_reg_bank.sv
// rtl/mem_reg_bank.sv - host register bank: status bits, edge counters, control registers
//
// Ports:
//   clk, rst        bus clock, synchronous active-high reset
//   din, we, re     host write data / write enable / read enable
//   addr            host word address
//   dout            registered read data, held while re is low
//   stat_in         asynchronous status levels
//   ctrl_out        control registers, reg k at [k*DATA_W +: DATA_W]
//   ctrl_wr         one-cycle strobe per control register after a write
module mem_reg_bank
    import mem_reg_bank_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 5,
    parameter int                N_STAT   = 4,
    parameter int                CNT_W    = 32,
    parameter int                N_CTRL   = 8,
    parameter logic [DATA_W-1:0] CTRL_RST = '0,
    parameter logic [DATA_W-1:0] ID_WORD  = DATA_W'(DEFAULT_ID)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        din,
    input  logic                     we,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        addr,
    output logic [DATA_W-1:0]        dout,
    input  logic [N_STAT-1:0]        stat_in,
    output logic [N_CTRL*DATA_W-1:0] ctrl_out,
    output logic [N_CTRL-1:0]        ctrl_wr
);

    localparam int ID_ADDR = id_addr(ADDR_W);
    localparam int HI_W    = CNT_W - DATA_W;

    if (cnt_hi_addr(N_STAT - 1) >= CTRL_BASE) begin : g_chk_stat
        $error("mem_reg_bank: N_STAT overflows the counter window");
    end
    if (CTRL_BASE + N_CTRL > ID_ADDR) begin : g_chk_ctrl
        $error("mem_reg_bank: control registers collide with ID address");
    end
    if (CNT_W <= DATA_W || CNT_W > 2 * DATA_W) begin : g_chk_cnt
        $error("mem_reg_bank: CNT_W must satisfy DATA_W < CNT_W <= 2*DATA_W");
    end

    logic [N_STAT-1:0] s_lvl;
    logic [N_STAT-1:0] clr;
    logic [N_STAT-1:0] snap;
    logic [DATA_W-1:0] cnt_lo  [N_STAT];
    logic [HI_W-1:0]   hi_snap [N_STAT];
    logic [DATA_W-1:0] ctrl    [N_CTRL];
    logic [N_CTRL-1:0] ctrl_we;
    logic [DATA_W-1:0] rd_val;
    int                addr_i;

    assign addr_i = int'(addr);

    for (genvar i = 0; i < N_STAT; i++) begin : g_cnt
        edge_event_counter #(
            .DATA_W(DATA_W),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .stat_in(stat_in[i]),
            .clr    (clr[i]),
            .snap   (snap[i]),
            .level  (s_lvl[i]),
            .cnt_lo (cnt_lo[i]),
            .hi_snap(hi_snap[i])
        );
    end

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
        assign ctrl_out[k*DATA_W +: DATA_W] = ctrl[k];
    end

    // Address decode and read mux; unmapped addresses read 0 and ignore writes.
    always_comb begin
        rd_val  = '0;
        clr     = '0;
        snap    = '0;
        ctrl_we = '0;
        for (int i = 0; i < N_STAT; i++) begin
            if (addr_i == STAT_BASE + i)
                rd_val = DATA_W'(s_lvl[i]);
            if (addr_i == cnt_lo_addr(i)) begin
                rd_val  = cnt_lo[i];
                snap[i] = re;
                clr[i]  = we;
            end
            if (addr_i == cnt_hi_addr(i))
                rd_val = DATA_W'(hi_snap[i]);
        end
        for (int k = 0; k < N_CTRL; k++) begin
            if (addr_i == CTRL_BASE + k) begin
                rd_val     = ctrl[k];
                ctrl_we[k] = we;
            end
        end
        if (addr_i == ID_ADDR)
            rd_val = ID_WORD;
    end

    // rd_val reflects pre-edge state, so a same-cycle read returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= '0;
            ctrl_wr <= '0;
            for (int k = 0; k < N_CTRL; k++)
                ctrl[k] <= CTRL_RST;
        end else begin
            if (re)
                dout <= rd_val;
            ctrl_wr <= ctrl_we;
            for (int k = 0; k < N_CTRL; k++)
                if (ctrl_we[k])
                    ctrl[k] <= din;
        end
    end

endmodule

// File: tb/tb_mem_reg_bank.sv
// tb/tb_mem_reg_bank.sv - self-checking bench for mem_reg_bank
module tb_mem_reg_bank;

    localparam int          DW   = 8;
    localparam int          AW   = 5;
    localparam int          NS   = 4;
    localparam int          CW   = 12;
    localparam int          NC   = 8;
    localparam logic [7:0]  CRST = 8'h3C;
    localparam logic [7:0]  IDW  = 8'hB6;
    localparam int          CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  din = '0;
    logic           we = 1'b0;
    logic           re = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [DW-1:0]  dout;
    logic [NS-1:0]  stat_in = '0;
    logic [NC*DW-1:0] ctrl_out;
    logic [NC-1:0]  ctrl_wr;

    int n_cmp = 0;
    int n_bad = 0;

    mem_reg_bank #(
        .DATA_W(DW), .ADDR_W(AW), .N_STAT(NS), .CNT_W(CW), .N_CTRL(NC),
        .CTRL_RST(CRST), .ID_WORD(IDW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .we(we), .re(re), .addr(addr),
        .dout(dout), .stat_in(stat_in), .ctrl_out(ctrl_out), .ctrl_wr(ctrl_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: status seen two samples late, counts of 0->1 steps
    // of that delayed level, host map as plain integer arithmetic.
    logic [NS-1:0] samp [3];
    int  m_cnt  [NS];
    int  m_snap [NS];
    int  m_ctrl [NC];
    int  m_dout;
    int  m_wr;
    bit  m_valid = 0;
    int  ma, mrv, mi;

    always @(posedge clk) begin
        m_valid = 1;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
            for (int k = 0; k < NC; k++) m_ctrl[k] = int'(CRST);
            m_dout = 0;
            m_wr   = 0;
            for (int j = 0; j < 3; j++) samp[j] = '0;
        end else begin
            ma  = int'(addr);
            mrv = 0;
            if (ma < NS)
                mrv = int'(samp[1][ma]);
            else if (ma >= 8 && ma < 8 + 2 * NS) begin
                mi  = (ma - 8) / 2;
                mrv = (ma % 2 == 0) ? (m_cnt[mi] % (1 << DW)) : m_snap[mi];
            end else if (ma >= 16 && ma < 16 + NC)
                mrv = m_ctrl[ma - 16];
            else if (ma == 31)
                mrv = int'(IDW);
            if (re) m_dout = mrv;
            for (int i = 0; i < NS; i++) begin
                if (re && ma == 8 + 2 * i) m_snap[i] = m_cnt[i] / (1 << DW);
                if (samp[1][i] && !samp[2][i] && m_cnt[i] < CMAX) m_cnt[i]++;
                if (we && ma == 8 + 2 * i) begin m_cnt[i] = 0; m_snap[i] = 0; end
            end
            m_wr = 0;
            if (we && ma >= 16 && ma < 16 + NC) begin
                m_ctrl[ma - 16] = int'(din);
                m_wr = 1 << (ma - 16);
            end
            samp[2] = samp[1];
            samp[1] = samp[0];
            samp[0] = stat_in;
        end
    end

    logic [NC*DW-1:0] exp_ctrl;
    always @(negedge clk) begin
        if (m_valid) begin
            for (int k = 0; k < NC; k++) exp_ctrl[k*DW +: DW] = m_ctrl[k][DW-1:0];
            chk("model dout", 64'(dout), 64'(m_dout[DW-1:0]));
            chk("model ctrl_wr", 64'(ctrl_wr), 64'(m_wr[NC-1:0]));
            chk("model ctrl_out", 64'(ctrl_out), 64'(exp_ctrl));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rd(input int a, input logic [DW-1:0] exp);
        addr = AW'(a);
        re   = 1'b1;
        tick();
        re   = 1'b0;
        chk($sformatf("read addr %0d", a), 64'(dout), 64'(exp));
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        addr = AW'(a);
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        stat_in = stat_in | m;
        tick(); tick();
        stat_in = stat_in & ~m;
        tick(); tick();
    endtask

    initial begin
        // Reset with all status inputs high
        stat_in = 4'hF;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset ctrl_out", 64'(ctrl_out), 64'h3C3C3C3C_3C3C3C3C);
        chk("reset dout", 64'(dout), 64'h0);
        chk("reset ctrl_wr", 64'(ctrl_wr), 64'h0);
        repeat (4) tick();
        expect_rd(8, 8'h01);
        expect_rd(10, 8'h01);
        expect_rd(9, 8'h00);
        stat_in = '0;
        repeat (3) tick();

        // Counting on input 2 and level visibility
        wr(12, 8'h00);
        repeat (5) pulse(4'b0100);
        expect_rd(12, 8'h05);
        expect_rd(13, 8'h00);
        stat_in = 4'b0100;
        expect_rd(2, 8'h00);
        expect_rd(2, 8'h00);
        expect_rd(2, 8'h01);
        stat_in = '0;
        expect_rd(2, 8'h01);
        expect_rd(2, 8'h01);
        expect_rd(2, 8'h00);

        // Atomic two-word read across a carry
        wr(8, 8'h00);
        repeat (255) pulse(4'b0001);
        expect_rd(8, 8'hFF);
        pulse(4'b0001);
        expect_rd(9, 8'h00);
        expect_rd(8, 8'h00);
        expect_rd(9, 8'h01);

        // Clear coinciding with an event on counter 1
        stat_in = 4'b0010;
        tick(); tick();
        wr(10, 8'h55);
        stat_in = '0;
        repeat (3) tick();
        expect_rd(10, 8'h00);
        expect_rd(11, 8'h00);

        // Saturation of counter 1
        repeat (CMAX + 3) pulse(4'b0010);
        expect_rd(10, 8'hFF);
        expect_rd(11, 8'h0F);

        // Control register write and strobe
        wr(19, 8'h12);
        chk("ctrl3 value", 64'(ctrl_out[3*DW +: DW]), 64'h12);
        chk("ctrl_wr strobe", 64'(ctrl_wr), 64'h08);
        tick();
        chk("ctrl_wr drop", 64'(ctrl_wr), 64'h00);
        addr = 5'd19; din = 8'hAB; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        chk("same-cycle rd/wr old", 64'(dout), 64'h12);
        expect_rd(19, 8'hAB);

        // Map edges
        expect_rd(31, 8'hB6);
        expect_rd(5, 8'h00);
        expect_rd(24, 8'h00);
        wr(0, 8'hFF);
        wr(9, 8'hFF);
        wr(31, 8'hFF);
        wr(24, 8'hFF);
        expect_rd(0, 8'h00);
        expect_rd(9, 8'h01);
        expect_rd(31, 8'hB6);
        chk("ctrl after ignored writes", 64'(ctrl_out), 64'h3C3C3C3C_AB3C3C3C);

        // Reset aborts a pending strobe
        addr = 5'd16; din = 8'h77; we = 1'b1;
        tick();
        we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ctrl_wr", 64'(ctrl_wr), 64'h00);
        chk("abort ctrl_out", 64'(ctrl_out), 64'h3C3C3C3C_3C3C3C3C);
        chk("abort dout", 64'(dout), 64'h00);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
